// File: rtl/nvdla_csb_responder.sv
// CSB target endpoint standing in for NVDLA on the csb2nvdla/nvdla2csb link.
// Holds a small register bank, answers reads after a fixed latency, returns
// completions for non-posted writes, and models the "operation done"
// interrupt with a countdown that OP_ENABLE kicks off.
module nvdla_csb_responder #(
    parameter int          N_REGS     = 16,
    parameter logic [15:0] BASE_ADDR  = 16'h0000,
    parameter int          RD_LATENCY = 2,
    parameter int          INTR_DELAY = 8,
    parameter logic [31:0] BAD_DATA   = 32'hDEAD_BEEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        csb2nvdla_valid_i,
    output logic        csb2nvdla_ready_o,
    input  logic [15:0] csb2nvdla_addr_i,
    input  logic [31:0] csb2nvdla_wdat_i,
    input  logic        csb2nvdla_write_i,
    input  logic        csb2nvdla_nposted_i,
    output logic        nvdla2csb_valid_o,
    output logic [31:0] nvdla2csb_data_o,
    output logic        nvdla2csb_wr_complete_o,
    output logic        intr_o,
    output logic        err_o
);

    // Indices 0 and 1 are OP_ENABLE and STATUS; only 2..N_REGS-1 are plain storage.
    localparam int PLAIN_REGS = (N_REGS > 2) ? (N_REGS - 2) : 1;
    localparam int RCW        = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam int ICW        = (INTR_DELAY > 1) ? $clog2(INTR_DELAY) : 1;
    localparam logic [RCW-1:0] RD_LOAD   = RCW'(RD_LATENCY - 1);
    localparam logic [ICW-1:0] INTR_LOAD = ICW'(INTR_DELAY - 1);

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        WR_RESP
    } csbState_e;

    csbState_e       state_q;
    logic [RCW-1:0]  rdCnt_q;
    logic [31:0]     capData_q;
    logic [31:0]     rspData_q;
    logic            rspValid_q;
    logic            wrComplete_q;
    logic            err_q;

    logic            opEn_q, opEn_d;
    logic            done_q, done_d;
    logic [ICW-1:0]  intrCnt_q, intrCnt_d;
    logic [31:0]     plain_q [PLAIN_REGS];

    logic [15:0]     reqIdx;
    logic            reqMapped;
    logic            reqAccept;
    logic            wrAccept;
    logic            wrOpEnable;
    logic            wrStatusClear;
    logic [31:0]     rdValue;

    // Wrapping subtraction makes addresses below the base land far above N_REGS.
    assign reqIdx    = csb2nvdla_addr_i - BASE_ADDR;
    assign reqMapped = (reqIdx < 16'(N_REGS));

    assign csb2nvdla_ready_o = (state_q == IDLE) && !rst_i;
    assign reqAccept         = csb2nvdla_valid_i && csb2nvdla_ready_o;
    assign wrAccept          = reqAccept && csb2nvdla_write_i && reqMapped;
    assign wrOpEnable        = wrAccept && (reqIdx == 16'd0);
    assign wrStatusClear     = wrAccept && (reqIdx == 16'd1) && csb2nvdla_wdat_i[0];

    assign nvdla2csb_valid_o       = rspValid_q;
    assign nvdla2csb_data_o        = rspData_q;
    assign nvdla2csb_wr_complete_o = wrComplete_q;
    assign err_o                   = err_q;
    assign intr_o                  = done_q;

    // Current value of the addressed register, sampled when a read is accepted.
    always_comb begin
        rdValue = BAD_DATA;
        if (reqMapped) begin
            if (reqIdx == 16'd0) begin
                rdValue = {31'd0, opEn_q};
            end else if (reqIdx == 16'd1) begin
                rdValue = {31'd0, done_q};
            end else begin
                for (int k = 0; k < PLAIN_REGS; k++) begin
                    if (reqIdx == 16'(k + 2)) begin
                        rdValue = plain_q[k];
                    end
                end
            end
        end
    end

    // Countdown and done flag: W1C loses to expiry, an OP_ENABLE write beats expiry.
    always_comb begin
        opEn_d    = opEn_q;
        done_d    = done_q;
        intrCnt_d = intrCnt_q;
        if (wrStatusClear) begin
            done_d = 1'b0;
        end
        if (opEn_q) begin
            if (intrCnt_q == '0) begin
                opEn_d = 1'b0;
                done_d = 1'b1;
            end else begin
                intrCnt_d = intrCnt_q - ICW'(1);
            end
        end
        if (wrOpEnable) begin
            opEn_d    = csb2nvdla_wdat_i[0];
            intrCnt_d = INTR_LOAD;
            if (!wrStatusClear) begin
                done_d = done_q;
            end
        end
    end

    // Register bank and interrupt state update.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            opEn_q    <= 1'b0;
            done_q    <= 1'b0;
            intrCnt_q <= '0;
            for (int k = 0; k < PLAIN_REGS; k++) begin
                plain_q[k] <= '0;
            end
        end else begin
            opEn_q    <= opEn_d;
            done_q    <= done_d;
            intrCnt_q <= intrCnt_d;
            for (int k = 0; k < PLAIN_REGS; k++) begin
                if (wrAccept && (reqIdx == 16'(k + 2))) begin
                    plain_q[k] <= csb2nvdla_wdat_i;
                end
            end
        end
    end

    // Transaction FSM with registered response, completion and error pulses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            rdCnt_q      <= '0;
            capData_q    <= '0;
            rspData_q    <= '0;
            rspValid_q   <= 1'b0;
            wrComplete_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            rspValid_q   <= 1'b0;
            wrComplete_q <= 1'b0;
            err_q        <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (reqAccept) begin
                        err_q <= !reqMapped;
                        if (csb2nvdla_write_i) begin
                            if (csb2nvdla_nposted_i) begin
                                state_q      <= WR_RESP;
                                wrComplete_q <= 1'b1;
                            end
                        end else begin
                            state_q   <= RD_WAIT;
                            rdCnt_q   <= RD_LOAD;
                            capData_q <= rdValue;
                            if (RD_LATENCY == 1) begin
                                rspValid_q <= 1'b1;
                                rspData_q  <= rdValue;
                            end
                        end
                    end
                end
                RD_WAIT: begin
                    if (rdCnt_q == '0) begin
                        state_q <= IDLE;
                    end else begin
                        rdCnt_q <= rdCnt_q - RCW'(1);
                        if (rdCnt_q == RCW'(1)) begin
                            rspValid_q <= 1'b1;
                            rspData_q  <= capData_q;
                        end
                    end
                end
                WR_RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nvdla_csb_responder.sv
// Directed bench for nvdla_csb_responder: read latency, write completions,
// back-to-back posted writes, unmapped accesses, interrupt timing and reset.
module tb_nvdla_csb_responder;

    localparam int          RD_LAT   = 2;
    localparam int          INTR_DLY = 8;
    localparam logic [15:0] BASE     = 16'h0000;
    localparam int          NREG     = 16;

    logic        clk_i;
    logic        rst_i;
    logic        reqValid;
    logic        reqReady;
    logic [15:0] reqAddr;
    logic [31:0] reqWdat;
    logic        reqWrite;
    logic        reqNposted;
    logic        rspValid;
    logic [31:0] rspData;
    logic        wrComplete;
    logic        intr;
    logic        err;

    int          assertCount = 0;
    int          failCount   = 0;
    int          cyc         = 0;
    int          lastAcceptCyc;
    logic [31:0] expQ [$];
    logic [31:0] model [NREG];

    nvdla_csb_responder #(
        .N_REGS     (NREG),
        .BASE_ADDR  (BASE),
        .RD_LATENCY (RD_LAT),
        .INTR_DELAY (INTR_DLY),
        .BAD_DATA   (32'hDEAD_BEEF)
    ) dut (
        .clk_i                   (clk_i),
        .rst_i                   (rst_i),
        .csb2nvdla_valid_i       (reqValid),
        .csb2nvdla_ready_o       (reqReady),
        .csb2nvdla_addr_i        (reqAddr),
        .csb2nvdla_wdat_i        (reqWdat),
        .csb2nvdla_write_i       (reqWrite),
        .csb2nvdla_nposted_i     (reqNposted),
        .nvdla2csb_valid_o       (rspValid),
        .nvdla2csb_data_o        (rspData),
        .nvdla2csb_wr_complete_o (wrComplete),
        .intr_o                  (intr),
        .err_o                   (err)
    );

    // Free-running clock and edge counter used to verify accept spacing.
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    // One comparison; a mismatch is counted and reported.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Read response and write completion must never coincide.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            checkOutput("exclusivePulse", 32'(rspValid & wrComplete), 32'd0);
        end
    end

    // Drive one request at a negedge once ready is seen; returns one negedge after acceptance.
    task automatic applyStimulus(input logic wr, input logic np, input logic [15:0] addr,
                                 input logic [31:0] data, output logic errFlag);
        int n;
        n = 0;
        while (reqReady !== 1'b1 && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        checkOutput("reqReady", 32'(reqReady), 32'd1);
        reqValid   = 1'b1;
        reqWrite   = wr;
        reqNposted = np;
        reqAddr    = addr;
        reqWdat    = data;
        @(negedge clk_i);
        lastAcceptCyc = cyc;
        reqValid = 1'b0;
        errFlag  = err;
    endtask

    // Issue a read, wait for its response and compare against the scoreboard.
    task automatic doRead(input string tag, input logic [15:0] addr, input logic [31:0] exp, output logic errFlag);
        int          lat;
        logic [31:0] want;
        expQ.push_back(exp);
        applyStimulus(1'b0, 1'b0, addr, 32'd0, errFlag);
        lat = 1;
        while (rspValid !== 1'b1 && lat < 20) begin
            checkOutput({tag, "_rdyWait"}, 32'(reqReady), 32'd0);
            @(negedge clk_i);
            lat++;
        end
        checkOutput({tag, "_latency"}, 32'(lat), 32'(RD_LAT));
        checkOutput({tag, "_rdyResp"}, 32'(reqReady), 32'd0);
        checkOutput({tag, "_errGone"}, 32'(err), 32'd0);
        want = 32'hxxxx_xxxx;
        if (expQ.size() != 0) want = expQ.pop_front();
        checkOutput({tag, "_data"}, rspData, want);
        @(negedge clk_i);
        checkOutput({tag, "_pulse"}, 32'(rspValid), 32'd0);
        checkOutput({tag, "_rdyIdle"}, 32'(reqReady), 32'd1);
        checkOutput({tag, "_dataHold"}, rspData, want);
    endtask

    // Read back every register index against the bench model.
    task automatic readAll(input string prefix);
        logic e;
        for (int i = 0; i < NREG; i++) begin
            doRead($sformatf("%s_r%0d", prefix, i), BASE + 16'(i), model[i], e);
        end
    endtask

    initial begin
        logic e;
        int   c2, c3, c4, n;

        rst_i      = 1'b1;
        reqValid   = 1'b0;
        reqAddr    = 16'd0;
        reqWdat    = 32'd0;
        reqWrite   = 1'b0;
        reqNposted = 1'b0;
        for (int i = 0; i < NREG; i++) model[i] = 32'd0;

        $display("[TB] reset");
        repeat (3) @(negedge clk_i);
        checkOutput("rstReady", 32'(reqReady), 32'd0);
        checkOutput("rstValid", 32'(rspValid), 32'd0);
        checkOutput("rstWrc", 32'(wrComplete), 32'd0);
        checkOutput("rstIntr", 32'(intr), 32'd0);
        checkOutput("rstErr", 32'(err), 32'd0);
        checkOutput("rstData", rspData, 32'd0);
        rst_i = 1'b0;
        @(negedge clk_i);
        checkOutput("relReady", 32'(reqReady), 32'd1);

        $display("[TB] read idx5 after reset");
        doRead("rd5", BASE + 16'd5, 32'd0, e);
        checkOutput("rd5_err", 32'(e), 32'd0);

        $display("[TB] non-posted write then read");
        applyStimulus(1'b1, 1'b1, BASE + 16'd3, 32'hCAFE_0001, e);
        model[3] = 32'hCAFE_0001;
        checkOutput("npw_wrc", 32'(wrComplete), 32'd1);
        checkOutput("npw_valid", 32'(rspValid), 32'd0);
        checkOutput("npw_ready", 32'(reqReady), 32'd0);
        @(negedge clk_i);
        checkOutput("npw_wrcPulse", 32'(wrComplete), 32'd0);
        checkOutput("npw_readyBack", 32'(reqReady), 32'd1);
        doRead("npw_rd3", BASE + 16'd3, model[3], e);

        $display("[TB] back-to-back posted writes");
        applyStimulus(1'b1, 1'b0, BASE + 16'd2, 32'h1111_0002, e);
        c2 = lastAcceptCyc;
        checkOutput("pw2_wrc", 32'(wrComplete), 32'd0);
        applyStimulus(1'b1, 1'b0, BASE + 16'd3, 32'h1111_0003, e);
        c3 = lastAcceptCyc;
        checkOutput("pw3_wrc", 32'(wrComplete), 32'd0);
        applyStimulus(1'b1, 1'b0, BASE + 16'd4, 32'h1111_0004, e);
        c4 = lastAcceptCyc;
        checkOutput("pw4_wrc", 32'(wrComplete), 32'd0);
        checkOutput("pw_gap23", 32'(c3 - c2), 32'd1);
        checkOutput("pw_gap34", 32'(c4 - c3), 32'd1);
        model[2] = 32'h1111_0002;
        model[3] = 32'h1111_0003;
        model[4] = 32'h1111_0004;
        doRead("pw_rd2", BASE + 16'd2, model[2], e);
        doRead("pw_rd3", BASE + 16'd3, model[3], e);
        doRead("pw_rd4", BASE + 16'd4, model[4], e);

        $display("[TB] unmapped accesses");
        doRead("bad_rd", BASE + 16'd16, 32'hDEAD_BEEF, e);
        checkOutput("bad_rdErr", 32'(e), 32'd1);
        applyStimulus(1'b1, 1'b0, BASE + 16'd16, 32'h5555_AAAB, e);
        checkOutput("bad_wrErr", 32'(e), 32'd1);
        checkOutput("bad_wrWrc", 32'(wrComplete), 32'd0);
        @(negedge clk_i);
        checkOutput("bad_wrErrPulse", 32'(err), 32'd0);
        readAll("bad");

        $display("[TB] interrupt countdown");
        applyStimulus(1'b1, 1'b0, BASE, 32'd1, e);
        checkOutput("irq_early", 32'(intr), 32'd0);
        n = 0;
        while (intr !== 1'b1 && n < 30) begin
            @(negedge clk_i);
            n++;
        end
        checkOutput("irq_delay", 32'(n), 32'(INTR_DLY));
        model[0] = 32'd0;
        model[1] = 32'd1;
        doRead("irq_status", BASE + 16'd1, model[1], e);
        doRead("irq_opEn", BASE, model[0], e);
        applyStimulus(1'b1, 1'b0, BASE + 16'd1, 32'd1, e);
        checkOutput("irq_w1cFall", 32'(intr), 32'd0);
        model[1] = 32'd0;
        doRead("irq_statusClr", BASE + 16'd1, model[1], e);

        $display("[TB] W1C on the expiry edge");
        applyStimulus(1'b1, 1'b0, BASE, 32'd1, e);
        repeat (INTR_DLY - 1) @(negedge clk_i);
        applyStimulus(1'b1, 1'b0, BASE + 16'd1, 32'd1, e);
        checkOutput("race_w1cSetWins", 32'(intr), 32'd1);
        @(negedge clk_i);
        checkOutput("race_w1cHold", 32'(intr), 32'd1);
        doRead("race_status", BASE + 16'd1, 32'd1, e);
        applyStimulus(1'b1, 1'b0, BASE + 16'd1, 32'd1, e);
        checkOutput("race_clear", 32'(intr), 32'd0);

        $display("[TB] OP_ENABLE write on the expiry edge");
        applyStimulus(1'b1, 1'b0, BASE, 32'd1, e);
        repeat (INTR_DLY - 1) @(negedge clk_i);
        applyStimulus(1'b1, 1'b0, BASE, 32'd1, e);
        checkOutput("restart_noDone", 32'(intr), 32'd0);
        n = 0;
        while (intr !== 1'b1 && n < 30) begin
            @(negedge clk_i);
            n++;
        end
        checkOutput("restart_delay", 32'(n), 32'(INTR_DLY));

        $display("[TB] reset during RD_WAIT");
        applyStimulus(1'b0, 1'b0, BASE + 16'd3, 32'd0, e);
        rst_i = 1'b1;
        @(negedge clk_i);
        checkOutput("midRst_valid0", 32'(rspValid), 32'd0);
        checkOutput("midRst_ready", 32'(reqReady), 32'd0);
        checkOutput("midRst_intr", 32'(intr), 32'd0);
        @(negedge clk_i);
        checkOutput("midRst_valid1", 32'(rspValid), 32'd0);
        checkOutput("midRst_data", rspData, 32'd0);
        checkOutput("midRst_err", 32'(err), 32'd0);
        rst_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            checkOutput($sformatf("postRst_valid%0d", i), 32'(rspValid), 32'd0);
            checkOutput($sformatf("postRst_ready%0d", i), 32'(reqReady), 32'd1);
        end
        for (int i = 0; i < NREG; i++) model[i] = 32'd0;
        readAll("postRst");

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/nvdla_csb_responder.md
Name: nvdla_csb_responder

Overview:
CSB target endpoint, the responder side of the CSB request/response protocol that the HWPE control FSM drives toward NVDLA. Accepts csb2nvdla requests, backs them with a small register bank, and returns read data or non-posted write completions on nvdla2csb. Also models the NVDLA "operation done" interrupt through a programmable countdown. Used as a standalone CSB stub for verifying the CSB initiator path and the wait-for-interrupt flow without the full NVDLA core.

Parameters:
N_REGS, 16, number of 32-bit registers; must be at least 2.
BASE_ADDR, 16'h0000, CSB word address of register 0.
RD_LATENCY, 2, cycles from read acceptance to response valid; must be at least 1.
INTR_DELAY, 8, cycles from an OP_ENABLE start until intr_o asserts; must be at least 1.
BAD_DATA, 32'hDEAD_BEEF, read data returned for an unmapped address.

Ports:
clk_i  in  1  clock.
rst_i  in  1  synchronous, active-high reset.
csb2nvdla_valid_i  in  1  request valid.
csb2nvdla_ready_o  out  1  request ready.
csb2nvdla_addr_i  in  16  CSB word address.
csb2nvdla_wdat_i  in  32  write data.
csb2nvdla_write_i  in  1  1 = write, 0 = read.
csb2nvdla_nposted_i  in  1  write needs a completion response.
nvdla2csb_valid_o  out  1  read response valid, 1-cycle pulse.
nvdla2csb_data_o  out  32  read response data.
nvdla2csb_wr_complete_o  out  1  non-posted write completion, 1-cycle pulse.
intr_o  out  1  level interrupt.
err_o  out  1  1-cycle pulse on any access to an unmapped address.

Behaviour:
- One clock (clk_i). rst_i is synchronous and active-high.
- Reset state:
  - All registers are 0.
  - csb2nvdla_ready_o is 0 while rst_i is high and 1 in the first cycle after release.
  - nvdla2csb_valid_o, nvdla2csb_wr_complete_o, intr_o and err_o are 0.
  - nvdla2csb_data_o is 0.
  - The FSM is in IDLE.
- Reset mid-transaction drops any pending response. No pulse is emitted after reset.
- Handshake: a request is accepted on a rising edge where valid_i and ready_o are both high. Only one transaction is outstanding at a time. ready_o is high only in IDLE.
- Address decode:
  - idx = addr_i − BASE_ADDR, using 16-bit unsigned arithmetic.
  - The address is mapped if BASE_ADDR ≤ addr_i < BASE_ADDR + N_REGS.
  - Unmapped write: ignored, err_o pulses the cycle after acceptance.
  - Unmapped read: returns BAD_DATA, err_o pulses the cycle after acceptance.
- FSM states: IDLE, RD_WAIT, WR_RESP.
  - IDLE + read accepted → RD_WAIT. Read data is captured at acceptance. A counter loads RD_LATENCY−1.
  - RD_WAIT: when the counter reaches 0, valid_o=1 and data_o=captured value for one cycle, then → IDLE. For an accept at edge T, valid_o is high in cycle T+RD_LATENCY. data_o holds its value until the next read response.
  - IDLE + write accepted: the register updates at the acceptance edge.
    - nposted=1 → WR_RESP. wr_complete_o=1 in the next cycle, then → IDLE.
    - nposted=0 → stay in IDLE. ready_o stays high, allowing back-to-back posted writes.
  - valid_o and wr_complete_o are never high in the same cycle.
- Register map:
  - idx0, OP_ENABLE:
    - A write with bit0=1 starts or restarts a countdown of INTR_DELAY cycles and sets OP_ENABLE bit0.
    - A write with bit0=0 clears bit0 and cancels the countdown.
  - idx1, STATUS:
    - bit0 = done. Writing 1 to bit0 clears it (W1C). Other bits read 0.
    - Writes with bit0=0 have no effect.
  - idx2..N_REGS−1: plain 32-bit read/write.
- Interrupt:
  - Countdown expiry: the cycle INTR_DELAY edges after the start edge.
  - At expiry: STATUS.done=1, OP_ENABLE bit0=0, intr_o=1.
  - intr_o = STATUS.done, registered.
  - If a W1C to STATUS and countdown expiry happen on the same edge, set wins and done stays 1.
  - If an OP_ENABLE write and expiry happen on the same edge, the write wins: countdown restarts and done is not set.

Test Plan:
- Reset, then read idx5 → valid_o high exactly 2 cycles after accept, data 0, ready_o low for 2 cycles.
- Non-posted write idx3=32'hCAFE_0001, then read idx3 → wr_complete_o pulse 1 cycle after accept, then read returns 32'hCAFE_0001.
- Three back-to-back posted writes to idx2..4 → accepted on 3 consecutive edges, no wr_complete_o; readback of idx2..4 matches.
- Read addr BASE_ADDR+16 → data 32'hDEAD_BEEF, err_o 1-cycle pulse; write to the same address leaves every register unchanged.
- Write OP_ENABLE=1 → intr_o rises 8 cycles later and STATUS reads 1. W1C STATUS=1 → intr_o falls next cycle. W1C issued on the exact expiry edge → intr_o stays high.
- Assert rst_i during RD_WAIT → no valid_o pulse; ready_o=1 after release; all registers read 0.
